ins_mem_ws: RTL and testbench
=============================

INS_MEM_WS -- requirements
Module: ins_mem_ws

Interface
REQ-001 Parameter ADDR_W, default 10, word-index width; DEPTH = 2**ADDR_W 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_3000, byte address of word 0 (text base).
REQ-003 Parameter WAIT_CYCLES, default 2, wait states per fetch, legal range 0..15.
REQ-004 Port clk  input  1  single clock; all state changes on posedge clk.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port req  input  1  fetch request; accepted on a posedge where req=1 and ready=1.
REQ-007 Port addr  input  32  byte fetch address; sampled only on acceptance.
REQ-008 Port ready  output  1  block can accept a request this cycle.
REQ-009 Port valid  output  1  one-cycle pulse; dout/fault hold a completed fetch.
REQ-010 Port dout  output  32  fetched instruction; held until the next valid.
REQ-011 Port fault  output  1  qualified by valid; fetch address illegal.
REQ-012 Port we  input  1  program-load write strobe.
REQ-013 Port waddr  input  ADDR_W  word index for the load write.
REQ-014 Port wdata  input  32  load write data.

Function
REQ-015 Word index = (addr - BASE_ADDR)[ADDR_W+1:2], 32-bit unsigned subtract, wrap-around allowed.
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP; ready=1 in IDLE and RESP, 0 in WAIT.
REQ-017 IDLE, on acceptance: go to WAIT if WAIT_CYCLES>0 (counter loaded WAIT_CYCLES-1), else RESP.
REQ-018 WAIT: counter decrements each cycle; at counter=0 go to RESP.
REQ-019 Array SHALL be read on the edge entering RESP, so writes committed during WAIT are returned.
REQ-020 Accept-to-valid latency SHALL be exactly WAIT_CYCLES+1 cycles; valid=1 only in RESP.
REQ-021 RESP: acceptance SHALL go to WAIT/RESP per REQ-017 (back-to-back); no acceptance -> IDLE.
REQ-022 Back-to-back throughput: WAIT_CYCLES=0 gives one fetch per cycle with continuous valid.
REQ-023 we=1 SHALL write wdata to mem[waddr] at posedge in any state, including during reset.
REQ-024 Write and read completion to the same index on the same edge SHALL return the old word.
REQ-025 req while ready=0 SHALL be ignored; the requester holds req until acceptance.

Reset
REQ-026 rst=1 at posedge: state IDLE, counter 0, valid 0, dout 0, fault 0; ready=1 the next cycle.
REQ-027 Reset mid-fetch SHALL abandon the fetch with no valid pulse.
REQ-028 Reset SHALL NOT clear array contents.

Configuration
REQ-029 With IMEM_FAULT_EN defined: addr[1:0]!=0 or (addr-BASE_ADDR) >= 4*DEPTH SHALL complete with normal latency, fault=1, dout=0.
REQ-030 Without IMEM_FAULT_EN: fault tied 0; index per REQ-015 with addr[1:0] ignored, out-of-range addresses alias.

Verification
REQ-031 WAIT_CYCLES=2, mem[5]=32'hDEADBEEF, accept addr=BASE+0x14 at edge 0 -> valid=1, dout=32'hDEADBEEF in cycle 3 only; ready=0 in cycles 1-2.
REQ-032 WAIT_CYCLES=0, req held, addrs BASE, BASE+4, BASE+8 -> valid high 3 consecutive cycles, dout mem[0],mem[1],mem[2].
REQ-033 Accept addr BASE+8, we waddr=2 wdata=32'h12345678 in WAIT cycle 1 -> dout=32'h12345678.
REQ-034 rst=1 during WAIT cycle 1 -> no valid pulse, dout=0, ready=1 next cycle; a new fetch returns the correct word.
REQ-035 IMEM_FAULT_EN: addr=BASE+2 -> valid, fault=1, dout=0; addr=BASE+4*DEPTH -> fault=1; without macro, same addr returns mem[0], fault=0.

Source files
------------

// File: rtl/ins_mem_ws.sv
// ins_mem_ws: wait-stated instruction fetch memory with a program-load write port.
// Build option IMEM_FAULT_EN: misaligned or out-of-range fetches complete with fault=1, dout=0.
module ins_mem_ws #(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [31:0]       addr,
  output logic              ready,
  output logic              valid,
  output logic [31:0]       dout,
  output logic              fault,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              ready_q;
  logic              valid_q;
  logic [31:0]       dout_q;
  logic              fault_q;
  logic [ADDR_W-1:0] idx_q;
  logic              flt_q;

  logic [31:0]       mem_q [DEPTH];

  logic [31:0]       off;
  logic [ADDR_W-1:0] idx_in;
  logic              flt_in;
  logic              unused_off;

  assign off    = addr - BASE_ADDR;
  assign idx_in = off[ADDR_W+1:2];

`ifdef IMEM_FAULT_EN
  assign flt_in     = (addr[1:0] != 2'b00) || ({1'b0, off} >= (33'd4 << ADDR_W));
  assign unused_off = 1'b0;
`else
  assign flt_in     = 1'b0;
  assign unused_off = ^{off[31:ADDR_W+2], off[1:0]};
`endif

  // Load port is independent of reset so a program can be loaded while the core is held.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      dout_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE, RESP: begin
          if (req) begin
            idx_q <= idx_in;
            flt_q <= flt_in;
            if (WAIT_CYCLES > 0) begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_CYCLES - 1);
              ready_q <= 1'b0;
            end else begin
              state_q <= RESP;
              ready_q <= 1'b1;
              valid_q <= 1'b1;
              dout_q  <= flt_in ? '0 : mem_q[idx_in];
              fault_q <= flt_in;
            end
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        WAIT: begin
          // Array is read on the edge entering RESP so loads landing during WAIT are seen.
          if (cnt_q == '0) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            valid_q <= 1'b1;
            dout_q  <= flt_q ? '0 : mem_q[idx_q];
            fault_q <= flt_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign valid = valid_q;
  assign dout  = dout_q;
  assign fault = fault_q;
endmodule

// File: tb/tb_ins_mem_ws.sv
// Bench for ins_mem_ws: two instances (WAIT_CYCLES=2 and 0) checked against a fetch-level model.
module tb_ins_mem_ws;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] BASE = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [AW-1:0] waddr = '0;

  logic rdy_a, vld_a, flt_a;
  logic [31:0] dout_a;
  logic rdy_b, vld_b, flt_b;
  logic [31:0] dout_b;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;
  int edge_n = 0;

  logic [31:0] mem_m [DEPTH];
  bit pend [2];
  int due [2];
  logic [31:0] paddr [2];
  bit ev [2];
  bit ef [2];
  bit er [2];
  logic [31:0] ed [2];
  int wc [2] = '{2, 0};

  ins_mem_ws #(.ADDR_W(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .ready(rdy_a), .valid(vld_a),
    .dout(dout_a), .fault(flt_a), .we(we), .waddr(waddr), .wdata(wdata));

  ins_mem_ws #(.ADDR_W(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .ready(rdy_b), .valid(vld_b),
    .dout(dout_b), .fault(flt_b), .we(we), .waddr(waddr), .wdata(wdata));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Outcome of fetching byte address a against the current model memory.
  task automatic resp(input logic [31:0] a, output logic [31:0] d, output bit f);
    logic [31:0] off;
    off = a - BASE;
    f = 1'b0;
`ifdef IMEM_FAULT_EN
    if ((a % 4) != 0 || off >= 32'(4 * DEPTH)) f = 1'b1;
`endif
    d = f ? 32'h0 : mem_m[(off / 4) % DEPTH];
  endtask

  // A fetch accepted at edge e is returned at edge e+W; ready is low while one is pending.
  task automatic model_step(input int d);
    bit rdy_now;
    if (rst) begin
      pend[d] = 1'b0; ev[d] = 1'b0; ed[d] = '0; ef[d] = 1'b0; er[d] = 1'b1;
      return;
    end
    ev[d] = 1'b0;
    rdy_now = !pend[d];
    if (pend[d] && edge_n == due[d]) begin
      resp(paddr[d], ed[d], ef[d]);
      ev[d] = 1'b1;
      pend[d] = 1'b0;
    end
    if (rdy_now && req) begin
      if (wc[d] == 0) begin
        resp(addr, ed[d], ef[d]);
        ev[d] = 1'b1;
      end else begin
        pend[d] = 1'b1;
        due[d] = edge_n + wc[d];
        paddr[d] = addr;
      end
    end
    er[d] = !pend[d];
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (we) mem_m[waddr] = wdata;
    edge_n++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("a_ready", {31'b0, rdy_a}, {31'b0, er[0]});
      check("a_valid", {31'b0, vld_a}, {31'b0, ev[0]});
      check("a_dout", dout_a, ed[0]);
      if (ev[0]) check("a_fault", {31'b0, flt_a}, {31'b0, ef[0]});
      check("b_ready", {31'b0, rdy_b}, {31'b0, er[1]});
      check("b_valid", {31'b0, vld_b}, {31'b0, ev[1]});
      check("b_dout", dout_b, ed[1]);
      if (ev[1]) check("b_fault", {31'b0, flt_b}, {31'b0, ef[1]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input int idx, input logic [31:0] val);
    we = 1'b1; waddr = AW'(idx); wdata = val;
    tick();
    we = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_d;
    logic exp_f;

    // Program load while reset is held.
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) load(i, 32'h5A00_0000 + 32'(i));
    load(0, 32'h1111_1111);
    load(1, 32'h2222_2222);
    load(2, 32'h3333_3333);
    load(3, 32'h3333_0003);
    load(5, 32'hDEAD_BEEF);
    chk_on = 1'b1;
    tick();
    check("rst_ready", {31'b0, rdy_a}, 32'd1);
    check("rst_valid", {31'b0, vld_a}, 32'd0);
    check("rst_dout", dout_a, 32'h0);
    rst = 1'b0;
    tick();

    // Two wait states: valid only in cycle 3, ready low in cycles 1-2.
    req = 1'b1; addr = BASE + 32'h14;
    tick();
    req = 1'b0;
    check("w2_c1_ready", {31'b0, rdy_a}, 32'd0);
    check("w2_c1_valid", {31'b0, vld_a}, 32'd0);
    check("w0_c1_valid", {31'b0, vld_b}, 32'd1);
    check("w0_c1_dout", dout_b, 32'hDEAD_BEEF);
    tick();
    check("w2_c2_ready", {31'b0, rdy_a}, 32'd0);
    check("w2_c2_valid", {31'b0, vld_a}, 32'd0);
    tick();
    check("w2_c3_valid", {31'b0, vld_a}, 32'd1);
    check("w2_c3_dout", dout_a, 32'hDEAD_BEEF);
    tick();
    check("w2_c4_valid", {31'b0, vld_a}, 32'd0);
    check("w2_c4_hold", dout_a, 32'hDEAD_BEEF);
    ticks(3);

    // Zero wait states, req held: one fetch per cycle.
    req = 1'b1; addr = BASE;
    tick();
    check("b2b_0_valid", {31'b0, vld_b}, 32'd1);
    check("b2b_0_dout", dout_b, 32'h1111_1111);
    addr = BASE + 32'h4;
    tick();
    check("b2b_1_valid", {31'b0, vld_b}, 32'd1);
    check("b2b_1_dout", dout_b, 32'h2222_2222);
    addr = BASE + 32'h8;
    tick();
    check("b2b_2_valid", {31'b0, vld_b}, 32'd1);
    check("b2b_2_dout", dout_b, 32'h3333_3333);
    req = 1'b0;
    ticks(4);

    // Load during WAIT is visible to the pending fetch.
    req = 1'b1; addr = BASE + 32'h8;
    tick();
    req = 1'b0; we = 1'b1; waddr = AW'(2); wdata = 32'h1234_5678;
    tick();
    we = 1'b0;
    tick();
    check("wait_wr_valid", {31'b0, vld_a}, 32'd1);
    check("wait_wr_dout", dout_a, 32'h1234_5678);
    ticks(3);

    // Load on the read edge itself returns the old word.
    req = 1'b1; addr = BASE + 32'hC;
    tick();
    req = 1'b0;
    tick();
    we = 1'b1; waddr = AW'(3); wdata = 32'hCAFE_F00D;
    tick();
    we = 1'b0;
    check("same_edge_dout", dout_a, 32'h3333_0003);
    req = 1'b1; addr = BASE + 32'hC;
    tick();
    req = 1'b0;
    check("after_wr_dout", dout_b, 32'hCAFE_F00D);
    ticks(4);

    // Reset during WAIT abandons the fetch; memory survives.
    req = 1'b1; addr = BASE + 32'h14;
    tick();
    req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", {31'b0, rdy_a}, 32'd1);
    check("midrst_dout", dout_a, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("midrst_novalid", {31'b0, vld_a}, 32'd0);
      tick();
    end
    req = 1'b1; addr = BASE + 32'h14;
    tick();
    req = 1'b0;
    ticks(2);
    check("postrst_valid", {31'b0, vld_a}, 32'd1);
    check("postrst_dout", dout_a, 32'hDEAD_BEEF);
    ticks(3);

    // Misaligned, past-the-end and below-base addresses.
`ifdef IMEM_FAULT_EN
    exp_d = 32'h0; exp_f = 1'b1;
`else
    exp_d = 32'h1111_1111; exp_f = 1'b0;
`endif
    req = 1'b1; addr = BASE + 32'h2;
    tick();
    check("mis_valid", {31'b0, vld_b}, 32'd1);
    check("mis_fault", {31'b0, flt_b}, {31'b0, exp_f});
    check("mis_dout", dout_b, exp_d);
    addr = BASE + 32'(4 * DEPTH);
    tick();
    check("oor_fault", {31'b0, flt_b}, {31'b0, exp_f});
    check("oor_dout", dout_b, exp_d);
    addr = BASE - 32'h4;
    tick();
    req = 1'b0;
    ticks(4);

    // Mixed traffic with interleaved loads; the model checks every cycle.
    for (int i = 0; i < 24; i++) begin
      req = ((i % 4) != 3);
      addr = BASE + 32'(4 * ((i * 7) % 16));
      if (i == 13) addr = addr + 32'h1;
      we = ((i % 3) == 0);
      waddr = AW'((i * 5) % 16);
      wdata = 32'hC000_0000 + 32'(i);
      tick();
    end
    req = 1'b0; we = 1'b0;
    ticks(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
